uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 106 ++++++++++
 tb/tb_uart_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input and received-byte outputs of the UART receiver
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_RX_Frame_Err;
  modport master (output i_RX_Serial, input o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err);
  modport slave (input i_RX_Serial, output o_RX_DV, o_RX_Byte, o_RX_Active, o_RX_Frame_Err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, framing-error detection
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input logic      i_Clk,
  input logic      i_Rst,
  uart_rx_if.slave rx
);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, RX_START_BIT, RX_DATA_BITS, RX_STOP_BIT, CLEANUP, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [7:0] cnt, cnt_n, data, data_n, byte_q, byte_n;
  logic [2:0] idx, idx_n;
  logic dv, dv_n, act, act_n, fe, fe_n;
  logic rx_s;
  assign rx_s = sync[1];
  assign rx.o_RX_DV = dv;
  assign rx.o_RX_Byte = byte_q;
  assign rx.o_RX_Active = act;
  assign rx.o_RX_Frame_Err = fe;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= IDLE;
      sync   <= 2'b11;
      cnt    <= '0;
      idx    <= '0;
      data   <= '0;
      byte_q <= '0;
      dv     <= 1'b0;
      act    <= 1'b0;
      fe     <= 1'b0;
    end else begin
      state  <= state_n;
      sync   <= {sync[0], rx.i_RX_Serial};
      cnt    <= cnt_n;
      idx    <= idx_n;
      data   <= data_n;
      byte_q <= byte_n;
      dv     <= dv_n;
      act    <= act_n;
      fe     <= fe_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    byte_n  = byte_q;
    dv_n    = dv;
    act_n   = act;
    fe_n    = fe;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : RX_START_BIT;
      end
      RX_START_BIT: begin
        cnt_n = cnt + 8'd1;
        if (cnt == HALF) begin
          cnt_n   = '0;
          act_n   = !rx_s;
          state_n = rx_s ? IDLE : RX_DATA_BITS;
        end
      end
      RX_DATA_BITS: begin
        cnt_n = cnt + 8'd1;
        if (cnt == LAST) begin
          cnt_n       = '0;
          data_n[idx] = rx_s;
          idx_n       = idx + 3'd1;
          state_n     = (idx == 3'd7) ? RX_STOP_BIT : RX_DATA_BITS;
        end
      end
      RX_STOP_BIT: begin
        cnt_n = cnt + 8'd1;
        if (cnt == LAST) begin
          cnt_n   = '0;
          act_n   = 1'b0;
          dv_n    = rx_s;
          fe_n    = !rx_s;
          byte_n  = rx_s ? data : byte_q;
          state_n = CLEANUP;
        end
      end
      CLEANUP: begin
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        state_n = fe ? WAIT_HIGH : IDLE;
      end
      // a line stuck low after a bad frame must not look like a new start bit
      WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        dv_n    = 1'b0;
        act_n   = 1'b0;
        fe_n    = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level model
module tb_uart_rx;
  localparam int N = 217;
  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  uart_rx_if bus ();
  uart_rx #(.CLKS_PER_BIT(N)) dut (.i_Clk(i_Clk), .i_Rst(i_Rst), .rx(bus));
  always #5 i_Clk = ~i_Clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int act_cnt = 0;
  int viol = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] got[$];
  int dv_cyc[$];
  logic [7:0] exp_q[$];
  always @(negedge i_Clk) begin
    cyc++;
    if (bus.o_RX_DV) begin
      got.push_back(bus.o_RX_Byte);
      dv_cyc.push_back(cyc);
    end
    if (bus.o_RX_Frame_Err) fe_cnt++;
    if (bus.o_RX_Active) act_cnt++;
    if ((bus.o_RX_DV && bus.o_RX_Frame_Err) || (bus.o_RX_DV && prev_dv) || (bus.o_RX_Frame_Err && prev_fe)) viol++;
    prev_dv = bus.o_RX_DV;
    prev_fe = bus.o_RX_Frame_Err;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // model: a frame with stop bit 1 delivers its byte, anything else delivers nothing
  task automatic send(input logic [7:0] b, input logic stop, input int t);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.i_RX_Serial = f[i];
      repeat (t) @(negedge i_Clk);
    end
    if (stop) exp_q.push_back(b);
  endtask
  task automatic idle(input int n);
    bus.i_RX_Serial = 1'b1;
    repeat (n) @(negedge i_Clk);
  endtask
  initial begin
    int n0, f0, a0, t;
    logic [7:0] r;
    logic [9:0] f;
    bus.i_RX_Serial = 1'b1;
    repeat (5) @(negedge i_Clk);
    chk("rst_dv", bus.o_RX_DV, 0);
    chk("rst_byte", bus.o_RX_Byte, 0);
    chk("rst_active", bus.o_RX_Active, 0);
    chk("rst_ferr", bus.o_RX_Frame_Err, 0);
    i_Rst = 1'b0;
    idle(20);
    send(8'hA5, 1'b1, N);
    idle(20);
    chk("a5_count", got.size(), 1);
    chk("a5_byte", bus.o_RX_Byte, 8'hA5);
    chk("a5_ferr", fe_cnt, 0);
    send(8'h00, 1'b1, N);
    send(8'hFF, 1'b1, N);
    idle(20);
    chk("b2b_count", got.size(), 3);
    chk("b2b_spacing", dv_cyc[2] - dv_cyc[1], 10 * N);
    chk("b2b_last", bus.o_RX_Byte, 8'hFF);
    n0 = got.size(); f0 = fe_cnt; a0 = act_cnt;
    bus.i_RX_Serial = 1'b0;
    repeat (50) @(negedge i_Clk);
    idle(300);
    chk("glitch_dv", got.size(), n0);
    chk("glitch_ferr", fe_cnt, f0);
    chk("glitch_active", act_cnt, a0);
    send(8'h3C, 1'b0, N);
    a0 = act_cnt;
    bus.i_RX_Serial = 1'b0;
    repeat (3000) @(negedge i_Clk);
    chk("ferr_pulse", fe_cnt, f0 + 1);
    chk("ferr_no_dv", got.size(), n0);
    chk("ferr_byte_held", bus.o_RX_Byte, 8'hFF);
    chk("ferr_no_restart", act_cnt, a0);
    idle(100);
    send(8'h81, 1'b1, N);
    idle(20);
    chk("after_ferr_count", got.size(), n0 + 1);
    chk("after_ferr_byte", bus.o_RX_Byte, 8'h81);
    r = 8'($urandom);
    f = {1'b1, r, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.i_RX_Serial = f[i];
      repeat (N) @(negedge i_Clk);
    end
    bus.i_RX_Serial = f[5];
    repeat (N / 2) @(negedge i_Clk);
    chk("mid_active", bus.o_RX_Active, 1);
    #3 i_Rst = 1'b1;
    #1;
    chk("async_dv", bus.o_RX_DV, 0);
    chk("async_byte", bus.o_RX_Byte, 0);
    chk("async_active", bus.o_RX_Active, 0);
    chk("async_ferr", bus.o_RX_Frame_Err, 0);
    bus.i_RX_Serial = 1'b1;
    repeat (5) @(negedge i_Clk);
    i_Rst = 1'b0;
    n0 = got.size();
    idle(300);
    chk("post_rst_quiet", got.size(), n0);
    send(8'h5A, 1'b1, N);
    idle(20);
    chk("post_rst_count", got.size(), n0 + 1);
    chk("post_rst_byte", bus.o_RX_Byte, 8'h5A);
    send(8'hC3, 1'b1, 213);
    idle(20);
    chk("skew_fast", bus.o_RX_Byte, 8'hC3);
    send(8'h3C, 1'b1, N);
    send(8'hC3, 1'b1, 221);
    idle(20);
    chk("skew_slow", bus.o_RX_Byte, 8'hC3);
    for (int k = 0; k < 6; k++) begin
      t = int'($urandom_range(221, 213));
      send(8'($urandom), 1'b1, t);
    end
    idle(50);
    chk("total_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk($sformatf("byte_%0d", i), got[i], exp_q[i]);
    chk("total_ferr", fe_cnt, 1);
    chk("pulse_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
